// File: rtl/instr_mem_writer_pkg.sv
// ============================================================================
// Module   : instr_mem_writer_pkg
// Purpose  : Shared Y86-64 encoding header: icodes, valC width, length table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_mem_writer_pkg;

  localparam int DATA_WID = 64;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ienc_state_e;

  // Encoded length in bytes; 0 marks an icode with no defined encoding.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET:                 len = 4'd1;
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: len = 4'd2;
      ICODE_JXX, ICODE_CALL:                            len = 4'd9;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:         len = 4'd10;
      default:                                          len = 4'd0;
    endcase
    return len;
  endfunction

  function automatic logic has_reg_byte(input logic [3:0] icode);
    logic [3:0] len;
    len = instr_len(icode);
    return (len == 4'd2) || (len == 4'd10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_writer_byte_sel.sv
// ============================================================================
// Module   : instr_byte_sel
// Purpose  : Returns byte k of the canonical Y86-64 image of latched fields.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_byte_sel
  import instr_mem_writer_pkg::*;
#(
  parameter int VALC_WID = 64
) (
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic [3:0]          ra,
  input  logic [3:0]          rb,
  input  logic [VALC_WID-1:0] valc,
  input  logic [3:0]          k,
  output logic [7:0]          byte_out
);

  logic [63:0] w_valc;
  logic [3:0]  w_len;
  logic [2:0]  w_idx;

  always_comb begin
    w_valc = 64'(valc);
    w_len  = instr_len(icode);
    // valC starts right after byte0 for jXX/call, after the register byte otherwise
    if (w_len == 4'd9) begin
      w_idx = 3'(k - 4'd1);
    end else begin
      w_idx = 3'(k - 4'd2);
    end

    if (k == 4'd0) begin
      byte_out = {icode, ifun};
    end else if ((k == 4'd1) && has_reg_byte(icode)) begin
      byte_out = {ra, rb};
    end else begin
      byte_out = w_valc[{w_idx, 3'b000} +: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_mem_writer.sv
// ============================================================================
// Module   : instr_mem_writer
// Purpose  : Serialises decoded Y86-64 instructions into byte memory writes.
//            Optional running XOR checksum enabled by macro IENC_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_writer
  import instr_mem_writer_pkg::*;
#(
  parameter int DATA_WID  = instr_mem_writer_pkg::DATA_WID,
  parameter int ADDR_WID  = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic [3:0]          rA,
  input  logic [3:0]          rB,
  input  logic [DATA_WID-1:0] valC,
  input  logic                restart,
  output logic                wr_en,
  output logic [ADDR_WID-1:0] wr_addr,
  output logic [7:0]          wr_data,
  output logic [ADDR_WID-1:0] next_pc,
  output logic                instr_done,
  output logic                err_icode,
  output logic                err_ovf,
  output logic [7:0]          checksum
);

  localparam logic [ADDR_WID-1:0] c_base_addr = ADDR_WID'(BASE_ADDR);
  localparam logic [ADDR_WID:0]   c_mem_depth = (ADDR_WID+1)'(1) << ADDR_WID;

  ienc_state_e r_state, w_state_nxt;

  logic [3:0]          r_icode, r_ifun, r_ra, r_rb, r_k, r_len;
  logic [DATA_WID-1:0] r_valc;
  logic [ADDR_WID-1:0] r_next_pc, r_wr_addr;
  logic [7:0]          r_wr_data;
  logic                r_full, r_wr_en, r_instr_done, r_err_icode, r_err_ovf;

  logic [3:0]          w_len_in;
  logic [ADDR_WID:0]   w_end, w_commit;
  logic [7:0]          w_byte;
  logic                w_accept, w_start, w_last, w_err_icode, w_err_ovf;

  assign in_ready = (r_state == ST_IDLE) && !restart;

  instr_byte_sel #(
    .VALC_WID (DATA_WID)
  ) u_byte_sel (
    .icode    (r_icode),
    .ifun     (r_ifun),
    .ra       (r_ra),
    .rb       (r_rb),
    .valc     (r_valc),
    .k        (r_k),
    .byte_out (w_byte)
  );

  always_comb begin
    w_len_in    = instr_len(icode);
    // One extra bit so an instruction ending exactly at the top does not wrap
    w_end       = {1'b0, r_next_pc} + (ADDR_WID+1)'(w_len_in);
    w_commit    = {1'b0, r_next_pc} + (ADDR_WID+1)'(r_len);
    w_accept    = in_valid && in_ready;
    w_start     = 1'b0;
    w_last      = 1'b0;
    w_err_icode = 1'b0;
    w_err_ovf   = 1'b0;
    w_state_nxt = r_state;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_len_in == 4'd0) begin
            w_err_icode = 1'b1;
          end else if (r_full || (w_end > c_mem_depth)) begin
            w_err_ovf = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_state_nxt = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        w_last = (r_k == (r_len - 4'd1));
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (restart) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icode      <= 4'd0;
      r_ifun       <= 4'd0;
      r_ra         <= 4'd0;
      r_rb         <= 4'd0;
      r_valc       <= '0;
      r_k          <= 4'd0;
      r_len        <= 4'd0;
      r_next_pc    <= c_base_addr;
      r_full       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 8'd0;
      r_instr_done <= 1'b0;
      r_err_icode  <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_instr_done <= 1'b0;
      r_err_icode  <= w_err_icode;
      r_err_ovf    <= w_err_ovf;
      if (restart) begin
        r_next_pc <= c_base_addr;
        r_full    <= 1'b0;
      end else begin
        if (w_start) begin
          r_icode <= icode;
          r_ifun  <= ifun;
          r_ra    <= rA;
          r_rb    <= rB;
          r_valc  <= valC;
          r_len   <= w_len_in;
          r_k     <= 4'd0;
        end
        if (r_state == ST_EMIT) begin
          r_wr_en      <= 1'b1;
          r_wr_addr    <= r_next_pc + ADDR_WID'(r_k);
          r_wr_data    <= w_byte;
          r_k          <= r_k + 4'd1;
          r_instr_done <= w_last;
          // Carry out of the pointer means memory is exactly full
          if (w_last) begin
            {r_full, r_next_pc} <= w_commit;
          end
        end
      end
    end
  end

`ifdef IENC_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= 8'd0;
    end else if (restart) begin
      r_checksum <= 8'd0;
    end else if (r_state == ST_EMIT) begin
      r_checksum <= r_checksum ^ w_byte;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 8'd0;
`endif

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign next_pc    = r_next_pc;
  assign instr_done = r_instr_done;
  assign err_icode  = r_err_icode;
  assign err_ovf    = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_writer.sv
// ============================================================================
// Module   : tb_instr_mem_writer
// Purpose  : Self-checking bench for instr_mem_writer (honours IENC_CHECKSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_writer;

  localparam int ADDR_WID = 11;
  localparam int DEPTH    = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        restart = 1'b0;
  logic [3:0]  icode = 4'd0, ifun = 4'd0, rA = 4'd0, rB = 4'd0;
  logic [63:0] valC = 64'd0;
  logic        in_ready, wr_en, instr_done, err_icode, err_ovf;
  logic [ADDR_WID-1:0] wr_addr, next_pc;
  logic [7:0]  wr_data, checksum;

  int        checks = 0;
  int        errors = 0;
  int        m_pc   = 0;
  bit        m_full = 1'b0;
  logic [7:0] m_cks = 8'd0;

  instr_mem_writer #(
    .DATA_WID  (64),
    .ADDR_WID  (ADDR_WID),
    .BASE_ADDR (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .ifun       (ifun),
    .rA         (rA),
    .rB         (rB),
    .valC       (valC),
    .restart    (restart),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .next_pc    (next_pc),
    .instr_done (instr_done),
    .err_icode  (err_icode),
    .err_ovf    (err_ovf),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  ic, fn, a, b;
    logic [63:0] c;
    int          len;
    logic [79:0] img;
  } vec_t;

  vec_t vecs[14];

  function automatic int ref_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  // Whole instruction image as one little-endian bit vector, byte0 in [7:0]
  function automatic logic [79:0] ref_image(input logic [3:0] ic, fn, a, b,
                                            input logic [63:0] c);
    logic [79:0] img;
    int len;
    len = ref_len(ic);
    img = '0;
    img[7:0] = {ic, fn};
    if (len == 2 || len == 10) img[15:8] = {a, b};
    if (len == 9)  img[71:8]  = c;
    if (len == 10) img[79:16] = c;
    return img;
  endfunction

  function automatic logic [7:0] exp_cks();
`ifdef IENC_CHECKSUM_EN
    return m_cks;
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_restart();
    m_pc = 0;
    m_full = 1'b0;
    m_cks = 8'd0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    model_restart();
    chk("restart_wr_en", 64'(wr_en), 64'd0);
    chk("restart_next_pc", 64'(next_pc), 64'd0);
    chk("restart_checksum", 64'(checksum), 64'd0);
  endtask

  task automatic run_instr(input logic [3:0] ic, fn, a, b, input logic [63:0] c,
                           input int len, input logic [79:0] img);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    chk("in_ready_before", 64'(in_ready), 64'd1);
    icode = ic; ifun = fn; rA = a; rB = b; valC = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (len == 0 || m_full || (m_pc + len > DEPTH)) begin
      chk("err_icode", 64'(err_icode), 64'(len == 0));
      chk("err_ovf", 64'(err_ovf), 64'(len != 0));
      chk("err_no_write", 64'(wr_en), 64'd0);
      chk("err_next_pc", 64'(next_pc), 64'(m_pc));
      chk("err_in_ready", 64'(in_ready), 64'd1);
      step();
      chk("err_pulse_len", 64'({err_icode, err_ovf, wr_en}), 64'd0);
    end else begin
      chk("accept_gap_wr_en", 64'(wr_en), 64'd0);
      for (int i = 0; i < len; i++) begin
        step();
        chk("emit_wr_en", 64'(wr_en), 64'd1);
        chk("emit_wr_addr", 64'(wr_addr), 64'((m_pc + i) % DEPTH));
        chk("emit_wr_data", 64'(wr_data), 64'(img[8*i +: 8]));
        chk("emit_instr_done", 64'(instr_done), 64'(i == len - 1));
        m_cks = m_cks ^ img[8*i +: 8];
      end
      m_pc = m_pc + len;
      if (m_pc == DEPTH) begin
        m_pc = 0;
        m_full = 1'b1;
      end
      chk("done_next_pc", 64'(next_pc), 64'(m_pc));
      chk("done_checksum", 64'(checksum), 64'(exp_cks()));
      chk("done_in_ready", 64'(in_ready), 64'd1);
    end
  endtask

  task automatic run_ref(input logic [3:0] ic, fn, a, b, input logic [63:0] c);
    run_instr(ic, fn, a, b, c, ref_len(ic), ref_image(ic, fn, a, b, c));
  endtask

  initial begin
    logic [7:0] cks_c0;
`ifdef IENC_CHECKSUM_EN
    cks_c0 = 8'hC0;
`else
    cks_c0 = 8'h00;
`endif
    vecs[0]  = '{4'h3, 4'h0, 4'hF, 4'h0, 64'h0123456789ABCDEF, 10, 80'h0123456789ABCDEFF030};
    vecs[1]  = '{4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 9, 80'h010070};
    vecs[2]  = '{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1, 80'h00};
    vecs[3]  = '{4'hC, 4'h0, 4'h1, 4'h2, 64'h55, 0, 80'h0};
    vecs[4]  = '{4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 2, 80'h1220};
    vecs[5]  = '{4'h6, 4'h1, 4'h3, 4'h4, 64'h0, 2, 80'h3461};
    vecs[6]  = '{4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 9, 80'h123480};
    vecs[7]  = '{4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 1, 80'h90};
    vecs[8]  = '{4'h4, 4'h0, 4'h5, 4'h6, 64'hFFFFFFFFFFFFFFF8, 10, 80'hFFFFFFFFFFFFFFF85640};
    vecs[9]  = '{4'hF, 4'h3, 4'h0, 4'h0, 64'h0, 0, 80'h0};
    vecs[10] = '{4'hA, 4'h0, 4'h7, 4'hF, 64'h0, 2, 80'h7FA0};
    vecs[11] = '{4'hB, 4'h0, 4'h8, 4'hF, 64'h0, 2, 80'h8FB0};
    vecs[12] = '{4'h5, 4'h0, 4'h1, 4'h2, 64'h8, 10, 80'h081250};
    vecs[13] = '{4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 1, 80'h10};

    // Reset values, both while held and after release
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({wr_en, instr_done, err_icode, err_ovf}), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_next_pc", 64'(next_pc), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_wr_en", 64'(wr_en), 64'd0);
    chk("post_rst_next_pc", 64'(next_pc), 64'd0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i].ic, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].c,
                vecs[i].len, vecs[i].img);
      if (i == 0) chk("cks_irmovq", 64'(checksum), 64'(cks_c0));
      if (i == 2) chk("pc_after_halt", 64'(next_pc), 64'd20);
    end

    // restart together with in_valid in IDLE: not accepted
    icode = 4'h1; ifun = 4'h0; in_valid = 1'b1; restart = 1'b1;
    #1;
    chk("restart_blocks_ready", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0; restart = 1'b0;
    model_restart();
    chk("restart_valid_no_err", 64'({err_icode, err_ovf, wr_en}), 64'd0);
    step();
    chk("restart_valid_no_write", 64'(wr_en), 64'd0);
    chk("restart_valid_pc", 64'(next_pc), 64'd0);

    // restart on the third EMIT cycle
    icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h0; valC = 64'h0123456789ABCDEF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rs_byte0", 64'(wr_data), 64'h30);
    step();
    chk("rs_byte1", 64'(wr_data), 64'hF0);
    do_restart();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs_no_more_writes", 64'(wr_en), 64'd0);
    end
    chk("rs_in_ready", 64'(in_ready), 64'd1);

    // Async reset after four bytes of an irmovq
    icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h1; valC = 64'hDEADBEEFCAFEF00D;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ar_wr_en_before", 64'(wr_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wr_en_immediate", 64'(wr_en), 64'd0);
    chk("ar_next_pc_immediate", 64'(next_pc), 64'd0);
    step();
    step();
    chk("ar_wr_en_held", 64'(wr_en), 64'd0);
    rst_n = 1'b1;
    model_restart();
    step();
    chk("ar_wr_en_after", 64'(wr_en), 64'd0);
    chk("ar_next_pc_after", 64'(next_pc), 64'd0);
    chk("ar_in_ready_after", 64'(in_ready), 64'd1);

    // Fill to 2040, then the top-of-memory boundary cases
    for (int i = 0; i < 204; i++) begin
      run_ref(4'h3, 4'h0, 4'hF, 4'(i), {$urandom, $urandom});
    end
    chk("fill_pc_2040", 64'(next_pc), 64'd2040);
    run_ref(4'h3, 4'h0, 4'hF, 4'h0, 64'h1);
    run_ref(4'h7, 4'h0, 4'hF, 4'hF, 64'h40);
    run_ref(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
    chk("nop_pc_2041", 64'(next_pc), 64'd2041);
    run_ref(4'hA, 4'h0, 4'h3, 4'hF, 64'h0);
    run_ref(4'hB, 4'h0, 4'h4, 4'hF, 64'h0);
    run_ref(4'h2, 4'h0, 4'h5, 4'h6, 64'h0);
    run_ref(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
    chk("full_pc_wrap", 64'(next_pc), 64'd0);
    run_ref(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
    do_restart();
    run_ref(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);

    // Randomised instruction stream against the reference model
    do_restart();
    for (int i = 0; i < 400; i++) begin
      if (i % 120 == 119) do_restart();
      run_ref(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_mem_writer.md
Name: instr_mem_writer

Overview:
- Y86-64 instruction encoder and loader: the write side of the byte-addressed instruction memory that the fetch stage decodes from.
- Accepts one decoded instruction per handshake (icode, ifun, rA, rB, valC).
- Serialises it into the canonical byte image, one byte write per cycle, at an auto-incrementing address.
- Used by the test harness and boot loader to build programs in place of a hex file.

Parameters:
- DATA_WID, 64, width of valC.
- ADDR_WID, 11, byte address width; memory depth is 2**ADDR_WID = 2048.
- BASE_ADDR, 0, write pointer value after reset or restart.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  writer can accept an instruction.
- icode  input  4  instruction code.
- ifun  input  4  function code.
- rA  input  4  register A (F = none).
- rB  input  4  register B (F = none).
- valC  input  DATA_WID  constant or destination.
- restart  input  1  synchronous pointer reset to BASE_ADDR; aborts any emission.
- wr_en  output  1  byte write strobe.
- wr_addr  output  ADDR_WID  byte address.
- wr_data  output  8  byte value.
- next_pc  output  ADDR_WID  address the next instruction will start at.
- instr_done  output  1  one-cycle pulse with the last byte of an instruction.
- err_icode  output  1  one-cycle pulse: icode C..F rejected.
- err_ovf  output  1  one-cycle pulse: instruction would not fit.
- checksum  output  8  see Optional Feature.

Behaviour:
- Reset values:
  - State IDLE, in_ready=1, wr_en=0, wr_addr=0, wr_data=0.
  - next_pc=BASE_ADDR; instr_done, err_icode, err_ovf = 0; checksum=0.
- Length table by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte.
  - 2 cmov/rrmovq, 6 OPq, A pushq, B popq: 2 bytes.
  - 7 jXX, 8 call: 9 bytes.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes.
- Byte image:
  - byte0 = {icode,ifun}.
  - If a register byte is present (len 2 or 10): byte1 = {rA,rB}.
  - valC follows little-endian (LSB first): from byte1 for jXX/call, from byte2 for len-10 instructions.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch all fields, set byte index k=0, go to EMIT.
  - Exception: icode >= C pulses err_icode next cycle, writes nothing, stays IDLE.
  - Exception: next_pc+len > 2**ADDR_WID (compute at ADDR_WID+1 bits, no wrap) pulses err_ovf, writes nothing, stays IDLE.
  - In both exception cases the instruction is consumed.
- EMIT:
  - in_ready=0.
  - Each cycle: wr_en=1, wr_addr=next_pc+k, wr_data=byte k, k++.
  - When k==len-1: assert instr_done with that byte, next_pc += len at the same edge, return to IDLE.
- Latency: first byte registered one cycle after acceptance. An instruction of length L occupies L cycles of wr_en plus one IDLE cycle before the next acceptance.
- Outputs are registered; wr_en is low in IDLE.
- restart has priority over everything except rst_n:
  - In any state: next cycle IDLE, next_pc=BASE_ADDR, wr_en=0, checksum=0.
  - A partial instruction is abandoned; bytes already written stay in memory.
- restart asserted together with in_valid in IDLE: restart wins and the instruction is not accepted (in_ready is treated as 0).
- Asynchronous reset mid-EMIT: outputs return to their reset values immediately and no further bytes are written.
- An instruction ending exactly at 2**ADDR_WID-1 is legal. next_pc then holds 2**ADDR_WID truncated (0) and an internal full flag is set. While full, every further instruction gets err_ovf until restart.

Optional Feature:
- Macro IENC_CHECKSUM_EN.
- Defined: checksum is the running XOR of every byte written since reset or restart, updated with each wr_en.
- Undefined: checksum is tied to 0 and no checksum logic is generated.

Decomposition:
- Shared header holds:
  - The icode constants (_HALT.._POPQ, including _JXX and _CALL).
  - DATA_WID.
  - The instruction-length function (icode -> 1/2/9/10, 0 for invalid).
- The fetch-side decoder must use the same header.
- One natural sub-module: instr_byte_sel, a combinational function of latched fields and k that returns byte k. The FSM, pointer and error logic stay in the top module.

Test Plan:
- irmovq: icode=3, ifun=0, rA=F, rB=0, valC=0x0123456789ABCDEF at pointer 0 -> writes 30 F0 EF CD AB 89 67 45 23 01 to addresses 0..9 on consecutive cycles; instr_done with address 9; next_pc=10.
- jmp 0x100 (7,0,valC=0x100) then halt (0,0) -> addresses 10..18 = 70 00 01 00 00 00 00 00 00; address 19 = 00; next_pc=20; one idle cycle between instructions.
- icode=C -> err_icode pulses once, no wr_en, next_pc unchanged, in_ready stays 1.
- Pointer at 2040, irmovq (len 10) -> err_ovf, no writes. Then nop -> write 10 at 2040, next_pc=2041.
- Reset mid-irmovq after 4 bytes -> wr_en drops immediately. After release: next_pc=BASE_ADDR, in_ready=1.
- restart on the third EMIT cycle -> no further writes, next_pc=0. With IENC_CHECKSUM_EN defined, checksum=0 afterwards. Also check the checksum equals the XOR of all bytes in the first scenario (0x30^0xF0^...^0x01).
